// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN inference chain: Q8.8 format, FSM encodings,
// accumulator sizing and the common output saturation function.
package cnn_pkg;

  localparam int unsigned CNN_DW   = 16;
  localparam int unsigned CNN_FRAC = 8;

  localparam logic [15:0] Q_ZERO = 16'h0000;
  localparam logic [15:0] Q_ONE  = 16'h0100;
  localparam logic [15:0] Q_HALF = 16'h0080;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_MIN  = 16'h8000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_BIAS  = 3'd1;
  localparam logic [2:0] ST_MAC   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] MAC_HOLD = 2'd0;
  localparam logic [1:0] MAC_LOAD = 2'd1;
  localparam logic [1:0] MAC_ACC  = 2'd2;
  localparam logic [1:0] MAC_CLR  = 2'd3;

  // Wide enough that a full dot product plus bias cannot overflow.
  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned n_in);
    return 2 * dw + $clog2(n_in) + 1;
  endfunction

  // Drop FRAC bits (floor), optional ReLU, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] v,
                                                   input int unsigned frac,
                                                   input int unsigned dw,
                                                   input logic relu);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (relu && (s < 64'sd0)) s = 64'sd0;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/dense_mac.sv
// Multiply-accumulate datapath for one neuron: bias load, product accumulate,
// clear, and the combinational output transform of the next accumulator value.
module dense_mac
  import cnn_pkg::*;
#(
  parameter int unsigned DW   = CNN_DW,
  parameter int unsigned FRAC = CNN_FRAC,
  parameter int unsigned N_IN = 400,
  parameter int unsigned RELU = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] bias,
  output logic [DW-1:0] res_c
);

  localparam int unsigned ACC_W = acc_w(DW, N_IN);
  localparam int unsigned PW    = 2 * DW;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;

  assign prod = PW'($signed(a)) * PW'($signed(b));

  always_comb begin
    acc_nxt = acc;
    case (op)
      MAC_LOAD: acc_nxt = ACC_W'($signed(bias)) <<< FRAC;
      MAC_ACC:  acc_nxt = acc + ACC_W'(prod);
      MAC_CLR:  acc_nxt = '0;
      default:  acc_nxt = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_nxt;
  end

  assign res_c = DW'(sat_round(64'(acc_nxt), FRAC, DW, logic'(RELU != 0)));

endmodule

// File: rtl/dense_layer.sv
// Dense layer engine: walks neurons and inputs, drives memory addresses and
// writes one saturated result per neuron.
module dense_layer
  import cnn_pkg::*;
#(
  parameter int unsigned N_IN     = 400,
  parameter int unsigned N_OUT    = 120,
  parameter int unsigned DW       = CNN_DW,
  parameter int unsigned FRAC     = CNN_FRAC,
  parameter int unsigned RELU     = 1,
  parameter int unsigned IN_BASE  = 0,
  parameter int unsigned OUT_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          work_finished,
  output logic [31:0]   rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [31:0]   w_addr,
  input  logic [DW-1:0] w_data,
  output logic [31:0]   b_addr,
  input  logic [DW-1:0] b_data,
  output logic [31:0]   wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_out_en
);

  localparam int unsigned IW = $clog2(N_IN + 1);
  localparam int unsigned JW = $clog2(N_OUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] i, i_nxt;
  logic [JW-1:0] j, j_nxt;
  logic [31:0]   ptr, ptr_nxt;
  logic [31:0]   rd_addr_nxt, w_addr_nxt, b_addr_nxt, wr_addr_nxt;
  logic [DW-1:0] wr_data_nxt;
  logic          wr_out_en_nxt, work_finished_nxt;
  logic [1:0]    mac_op;
  logic [DW-1:0] res_c;

  dense_mac #(
    .DW   (DW),
    .FRAC (FRAC),
    .N_IN (N_IN),
    .RELU (RELU)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (mac_op),
    .a     (rd_data),
    .b     (w_data),
    .bias  (b_data),
    .res_c (res_c)
  );

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_nxt         = state;
    i_nxt             = i;
    j_nxt             = j;
    ptr_nxt           = ptr;
    rd_addr_nxt       = rd_addr;
    w_addr_nxt        = w_addr;
    b_addr_nxt        = b_addr;
    wr_addr_nxt       = wr_addr;
    wr_data_nxt       = wr_data;
    wr_out_en_nxt     = 1'b0;
    work_finished_nxt = 1'b0;
    mac_op            = MAC_HOLD;

    if (!en && (state != ST_IDLE) && (state != ST_DONE)) begin
      state_nxt   = ST_IDLE;
      i_nxt       = '0;
      j_nxt       = '0;
      ptr_nxt     = '0;
      rd_addr_nxt = '0;
      w_addr_nxt  = '0;
      b_addr_nxt  = '0;
      wr_addr_nxt = '0;
      wr_data_nxt = '0;
      mac_op      = MAC_CLR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state_nxt  = ST_BIAS;
            i_nxt      = '0;
            j_nxt      = '0;
            ptr_nxt    = '0;
            b_addr_nxt = '0;
          end
        end
        ST_BIAS: begin
          state_nxt   = ST_MAC;
          i_nxt       = '0;
          rd_addr_nxt = 32'(IN_BASE);
          w_addr_nxt  = ptr;
          ptr_nxt     = ptr + 32'd1;
        end
        ST_MAC: begin
          // Data returning now belongs to index i-1; index 0 sees the bias instead.
          mac_op = (i == '0) ? MAC_LOAD : MAC_ACC;
          if (i == I_LAST) begin
            state_nxt = ST_DRAIN;
          end else begin
            i_nxt       = i + IW'(1);
            rd_addr_nxt = 32'(IN_BASE) + 32'(i) + 32'd1;
            w_addr_nxt  = ptr;
            ptr_nxt     = ptr + 32'd1;
          end
        end
        ST_DRAIN: begin
          mac_op        = MAC_ACC;
          state_nxt     = ST_WRITE;
          wr_out_en_nxt = 1'b1;
          wr_addr_nxt   = 32'(OUT_BASE) + 32'(j);
          wr_data_nxt   = res_c;
        end
        ST_WRITE: begin
          if (j == J_LAST) begin
            state_nxt         = ST_DONE;
            work_finished_nxt = 1'b1;
          end else begin
            state_nxt  = ST_BIAS;
            j_nxt      = j + JW'(1);
            b_addr_nxt = 32'(j) + 32'd1;
          end
        end
        ST_DONE: begin
          if (en) work_finished_nxt = 1'b1;
          else    state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      i             <= '0;
      j             <= '0;
      ptr           <= '0;
      rd_addr       <= '0;
      w_addr        <= '0;
      b_addr        <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_out_en     <= 1'b0;
      work_finished <= 1'b0;
    end else begin
      state         <= state_nxt;
      i             <= i_nxt;
      j             <= j_nxt;
      ptr           <= ptr_nxt;
      rd_addr       <= rd_addr_nxt;
      w_addr        <= w_addr_nxt;
      b_addr        <= b_addr_nxt;
      wr_addr       <= wr_addr_nxt;
      wr_data       <= wr_data_nxt;
      wr_out_en     <= wr_out_en_nxt;
      work_finished <= work_finished_nxt;
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer: two small instances (ReLU on/off) sharing memories and a
// full-size instance, all checked every cycle against a dot-product reference.
module tb_dense_layer;

  typedef struct {
    int          t;
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_s = 1'b0;
  logic en_f = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] feat_mem [400];
  logic [15:0] w_mem    [48000];
  logic [15:0] b_mem    [120];

  logic        a_wf, a_we, b_wf, b_we, f_wf, f_we;
  logic [31:0] a_rd_addr, a_w_addr, a_b_addr, a_wr_addr;
  logic [31:0] b_rd_addr, b_w_addr, b_b_addr, b_wr_addr;
  logic [31:0] f_rd_addr, f_w_addr, f_b_addr, f_wr_addr;
  logic [15:0] a_rd_data, a_w_data, a_b_data, a_wr_data;
  logic [15:0] b_rd_data, b_w_data, b_b_data, b_wr_data;
  logic [15:0] f_rd_data, f_w_data, f_b_data, f_wr_data;

  dense_layer #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(8), .RELU(1), .IN_BASE(8), .OUT_BASE(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_s), .work_finished(a_wf),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .w_addr(a_w_addr), .w_data(a_w_data),
    .b_addr(a_b_addr), .b_data(a_b_data), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_out_en(a_we));

  dense_layer #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(8), .RELU(0), .IN_BASE(8), .OUT_BASE(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_s), .work_finished(b_wf),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .w_addr(b_w_addr), .w_data(b_w_data),
    .b_addr(b_b_addr), .b_data(b_b_data), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_out_en(b_we));

  dense_layer #(.N_IN(400), .N_OUT(120), .DW(16), .FRAC(8), .RELU(1), .IN_BASE(0), .OUT_BASE(1000)) u_f (
    .clk(clk), .rst_n(rst_n), .en(en_f), .work_finished(f_wf),
    .rd_addr(f_rd_addr), .rd_data(f_rd_data), .w_addr(f_w_addr), .w_data(f_w_data),
    .b_addr(f_b_addr), .b_data(f_b_data), .wr_addr(f_wr_addr), .wr_data(f_wr_data),
    .wr_out_en(f_we));

  function automatic logic [15:0] mem_rd(input int sel, input logic [31:0] a, input int base);
    int k;
    k = int'(a) - base;
    if (sel == 0) return (k >= 0 && k < 400)   ? feat_mem[k] : 16'hDEAD;
    if (sel == 1) return (k >= 0 && k < 48000) ? w_mem[k]    : 16'hDEAD;
    return (k >= 0 && k < 120) ? b_mem[k] : 16'hDEAD;
  endfunction

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    a_rd_data <= mem_rd(0, a_rd_addr, 8);
    a_w_data  <= mem_rd(1, a_w_addr, 0);
    a_b_data  <= mem_rd(2, a_b_addr, 0);
    b_rd_data <= mem_rd(0, b_rd_addr, 8);
    b_w_data  <= mem_rd(1, b_w_addr, 0);
    b_b_data  <= mem_rd(2, b_b_addr, 0);
    f_rd_data <= mem_rd(0, f_rd_addr, 0);
    f_w_data  <= mem_rd(1, f_w_addr, 0);
    f_b_data  <= mem_rd(2, f_b_addr, 0);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference neuron: bias*2^FRAC plus the dot product, floor shift, ReLU, clamp.
  function automatic logic [15:0] exp_out(input int j, input int nin, input bit relu);
    longint acc;
    acc = longint'($signed(b_mem[j])) * 256;
    for (int k = 0; k < nin; k++)
      acc += longint'($signed(feat_mem[k])) * longint'($signed(w_mem[j * nin + k]));
    acc = acc >>> 8;
    if (relu && acc < 0) acc = 0;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  // Cycles elapsed since the run request was first seen (0 = idle).
  int t_s = 0;
  int t_f = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_s = 0;
      t_f = 0;
    end else begin
      t_s = en_s ? t_s + 1 : 0;
      t_f = en_f ? t_f + 1 : 0;
    end
  end

  task automatic check_dut(input string nm, input int t, input int nin, input int nout,
                           input bit relu, input int obase, input logic we,
                           input logic [31:0] wa, input logic [15:0] wd, input logic wf);
    int per;
    bit exp_we;
    int j;
    per    = nin + 3;
    exp_we = (t > 0) && (t % per == 0) && (t / per <= nout);
    chk({nm, ".wr_out_en"}, 64'(we), 64'(exp_we));
    chk({nm, ".work_finished"}, 64'(wf), 64'(t > nout * per));
    if (exp_we) begin
      j = t / per - 1;
      chk({nm, ".wr_addr"}, 64'(wa), 64'(obase + j));
      chk({nm, ".wr_data"}, 64'(wd), 64'(exp_out(j, nin, relu)));
    end
  endtask

  wr_t qa[$], qb[$], qf[$];
  int wfa_t = -1, wff_t = -1;
  logic a_wf_q = 1'b0, f_wf_q = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check_dut("A", t_s, 4, 2, 1'b1, 16, a_we, a_wr_addr, a_wr_data, a_wf);
      check_dut("B", t_s, 4, 2, 1'b0, 16, b_we, b_wr_addr, b_wr_data, b_wf);
      check_dut("F", t_f, 400, 120, 1'b1, 1000, f_we, f_wr_addr, f_wr_data, f_wf);
      if (a_we) qa.push_back('{t_s, a_wr_addr, a_wr_data});
      if (b_we) qb.push_back('{t_s, b_wr_addr, b_wr_data});
      if (f_we) qf.push_back('{t_f, f_wr_addr, f_wr_data});
      if (a_wf && !a_wf_q) wfa_t = t_s;
      if (f_wf && !f_wf_q) wff_t = t_f;
    end
    a_wf_q = a_wf;
    f_wf_q = f_wf;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_small(input logic [15:0] f, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < 4; k++) feat_mem[k] = f;
    for (int k = 0; k < 8; k++) w_mem[k] = w;
    for (int k = 0; k < 2; k++) b_mem[k] = b;
  endtask

  task automatic run_small(input int n);
    qa.delete();
    qb.delete();
    wfa_t = -1;
    en_s = 1'b1;
    step(n);
  endtask

  task automatic stop_small();
    en_s = 1'b0;
    step(2);
  endtask

  task automatic chk_pair(input string nm, input logic [15:0] ea, input logic [15:0] eb);
    chk({nm, ".A.count"}, 64'(qa.size()), 64'd2);
    chk({nm, ".B.count"}, 64'(qb.size()), 64'd2);
    if (qa.size() == 2 && qb.size() == 2) begin
      chk({nm, ".A.w0"}, 64'(qa[0].data), 64'(ea));
      chk({nm, ".A.w1"}, 64'(qa[1].data), 64'(ea));
      chk({nm, ".B.w0"}, 64'(qb[0].data), 64'(eb));
      chk({nm, ".B.w1"}, 64'(qb[1].data), 64'(eb));
    end
  endtask

  logic [15:0] prev0, prev1;

  initial begin
    for (int k = 0; k < 400; k++) feat_mem[k] = 16'h0;
    for (int k = 0; k < 48000; k++) w_mem[k] = 16'h0;
    for (int k = 0; k < 120; k++) b_mem[k] = 16'h0;

    #12;
    chk("reset.wr_out_en", 64'(a_we), 64'd0);
    chk("reset.work_finished", 64'(f_wf), 64'd0);
    chk("reset.rd_addr", 64'(a_rd_addr), 64'd0);
    chk("reset.wr_data", 64'(a_wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // Basic: 4 * (1.0 * 0.5) + 0.25 = 2.25
    fill_small(16'h0100, 16'h0080, 16'h0040);
    run_small(17);
    chk_pair("basic", 16'h0240, 16'h0240);
    if (qa.size() == 2) begin
      chk("basic.t0", 64'(qa[0].t), 64'd7);
      chk("basic.t1", 64'(qa[1].t), 64'd14);
      chk("basic.addr0", 64'(qa[0].addr), 64'd16);
      chk("basic.addr1", 64'(qa[1].addr), 64'd17);
    end
    chk("basic.wf_cycle", 64'(wfa_t), 64'd15);
    stop_small();

    // ReLU: 4 * -0.5 + 0.25 = -1.75
    fill_small(16'h0100, 16'hFF80, 16'h0040);
    run_small(17);
    chk_pair("relu", 16'h0000, 16'hFE40);
    stop_small();

    fill_small(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_small(17);
    chk_pair("sat_pos", 16'h7FFF, 16'h7FFF);
    stop_small();

    fill_small(16'h7FFF, 16'h8000, 16'h7FFF);
    run_small(17);
    chk_pair("sat_neg", 16'h0000, 16'h8000);
    stop_small();

    // Random data, then abort in the middle of neuron 1's MAC phase.
    for (int k = 0; k < 4; k++) feat_mem[k] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 8; k++) w_mem[k] = 16'($urandom_range(0, 511)) - 16'd256;
    for (int k = 0; k < 2; k++) b_mem[k] = 16'($urandom_range(0, 65535));
    run_small(10);
    en_s = 1'b0;
    step(6);
    chk("abort.A.count", 64'(qa.size()), 64'd1);
    chk("abort.A.wf", 64'(a_wf), 64'd0);
    chk("abort.A.wr_out_en", 64'(a_we), 64'd0);
    run_small(17);
    chk("restart.A.count", 64'(qa.size()), 64'd2);
    chk("restart.B.count", 64'(qb.size()), 64'd2);
    stop_small();

    // Asynchronous reset while the first write is on the bus.
    run_small(7);
    rst_n = 1'b0;
    #1;
    chk("areset.wr_out_en", 64'(a_we), 64'd0);
    chk("areset.wr_addr", 64'(a_wr_addr), 64'd0);
    chk("areset.wr_data", 64'(a_wr_data), 64'd0);
    chk("areset.rd_addr", 64'(a_rd_addr), 64'd0);
    chk("areset.w_addr", 64'(a_w_addr), 64'd0);
    chk("areset.b_addr", 64'(a_b_addr), 64'd0);
    chk("areset.wf", 64'(a_wf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    step(17);
    chk("after_reset.count", 64'(qa.size()), 64'd2);
    prev0 = (qa.size() > 0) ? qa[0].data : 16'hx;
    prev1 = (qa.size() > 1) ? qa[1].data : 16'hx;
    en_s = 1'b0;
    step(1);
    run_small(17);
    chk("b2b.count", 64'(qa.size()), 64'd2);
    if (qa.size() == 2) begin
      chk("b2b.w0", 64'(qa[0].data), 64'(prev0));
      chk("b2b.w1", 64'(qa[1].data), 64'(prev1));
    end
    stop_small();

    // Full-size run with random Q8.8 data.
    for (int k = 0; k < 400; k++) feat_mem[k] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < 48000; k++) w_mem[k] = 16'($urandom_range(0, 63)) - 16'd32;
    for (int k = 0; k < 120; k++) b_mem[k] = 16'($urandom_range(0, 65535));
    qf.delete();
    wff_t = -1;
    en_f = 1'b1;
    step(48365);
    chk("full.count", 64'(qf.size()), 64'd120);
    chk("full.wf_cycle", 64'(wff_t), 64'd48361);
    if (qf.size() > 0) chk("full.t0", 64'(qf[0].t), 64'd403);
    en_f = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
